// File: rtl/pipe_addmul_pkg.sv
// Shared sizing helpers and the default stage payload for the add-multiply pipe.
// Partial products are walked in schoolbook order: ascending weight k = i+j, low i first.
package pipe_addmul_pkg;

    localparam int DEF_W     = 32;
    localparam int DEF_LIMB  = 16;
    localparam int DEF_TAG_W = 4;

    function automatic int n_limbs(input int w, input int limb);
        return w / limb;
    endfunction

    function automatic int pipe_latency(input int w, input int limb);
        int n;
        n = n_limbs(w, limb);
        return 2 + n * n;
    endfunction

    // Holds the running carry plus up to N unshifted limb products.
    function automatic int acc_width(input int w, input int limb);
        return 2 * limb + $clog2(n_limbs(w, limb)) + 2;
    endfunction

    function automatic int pp_i(input int w, input int limb, input int s);
        int n, c;
        n    = n_limbs(w, limb);
        c    = 0;
        pp_i = 0;
        for (int k = 0; k < 2 * n - 1; k++)
            for (int i = 0; i < n; i++)
                if (i <= k && k - i < n) begin
                    if (c == s) pp_i = i;
                    c++;
                end
    endfunction

    function automatic int pp_j(input int w, input int limb, input int s);
        int n, c;
        n    = n_limbs(w, limb);
        c    = 0;
        pp_j = 0;
        for (int k = 0; k < 2 * n - 1; k++)
            for (int i = 0; i < n; i++)
                if (i <= k && k - i < n) begin
                    if (c == s) pp_j = k - i;
                    c++;
                end
    endfunction

    localparam int DEF_ACC_W = acc_width(DEF_W, DEF_LIMB);

    typedef struct packed {
        logic [DEF_ACC_W-1:0]  acc;
        logic [2*DEF_W-1:0]    res;
        logic [DEF_W-1:0]      a;
        logic [DEF_W-1:0]      b;
        logic [DEF_TAG_W-1:0]  tag;
        logic                  vld;
    } addmul_pl_t;

endpackage

// File: rtl/pipe_addmul_stage.sv
// One partial-product stage: adds a_I*b_J into the running accumulator and,
// when it is the last product of its weight, retires that result limb.
module pipe_addmul_stage
    import pipe_addmul_pkg::*;
#(
    parameter int  W    = DEF_W,
    parameter int  LIMB = DEF_LIMB,
    parameter int  I    = 0,
    parameter int  J    = 0,
    parameter type pl_t = addmul_pl_t
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_hold,
    input  logic i_flush,
    input  pl_t  i_pl,
    output pl_t  o_pl
);

    localparam int N      = n_limbs(W, LIMB);
    localparam int K      = I + J;
    localparam int ACC_W  = acc_width(W, LIMB);
    localparam bit COMMIT = (I == ((K < N) ? K : N - 1));
    localparam bit FINAL  = (K == 2 * N - 2);

    logic [LIMB-1:0]   w_a;
    logic [LIMB-1:0]   w_b;
    logic [2*LIMB-1:0] w_pp;
    logic [ACC_W-1:0]  w_acc;
    pl_t               w_nxt;
    pl_t               r_pl;

    assign w_a   = i_pl.a[I*LIMB +: LIMB];
    assign w_b   = i_pl.b[J*LIMB +: LIMB];
    assign w_pp  = {{LIMB{1'b0}}, w_a} * {{LIMB{1'b0}}, w_b};
    // Accumulator is always aligned to weight K, so the product adds unshifted.
    assign w_acc = i_pl.acc + ACC_W'(w_pp);

    always_comb begin
        w_nxt     = i_pl;
        w_nxt.acc = w_acc;
        if (COMMIT) begin
            w_nxt.res[K*LIMB +: LIMB] = w_acc[LIMB-1:0];
            w_nxt.acc                 = w_acc >> LIMB;
        end
        if (FINAL)
            w_nxt.res[(K+1)*LIMB +: LIMB] = w_acc[2*LIMB-1:LIMB];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_pl <= '0;
        else if (i_flush)
            r_pl.vld <= 1'b0;
        else if (!i_hold)
            r_pl <= w_nxt;
    end

    assign o_pl = r_pl;

endmodule

// File: rtl/pipe_addmul_bp.sv
// Backpressured pipeline computing (in_1 + in_2) * in_3 with one LIMB x LIMB
// partial product per stage; whole pipe freezes while the output is stalled.
module pipe_addmul_bp
    import pipe_addmul_pkg::*;
#(
    parameter int W     = 32,
    parameter int LIMB  = 16,
    parameter int TAG_W = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [W-2:0]       in_1,
    input  logic [W-2:0]       in_2,
    input  logic [W-1:0]       in_3,
    input  logic [TAG_W-1:0]   in_tag,
    input  logic               flush,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*W-1:0]     out,
    output logic [TAG_W-1:0]   out_tag,
    output logic               busy
);

    localparam int N     = n_limbs(W, LIMB);
    localparam int NN    = N * N;
    localparam int ACC_W = acc_width(W, LIMB);

    typedef struct packed {
        logic [ACC_W-1:0]  acc;
        logic [2*W-1:0]    res;
        logic [W-1:0]      a;
        logic [W-1:0]      b;
        logic [TAG_W-1:0]  tag;
        logic              vld;
    } pl_t;

    logic [W-2:0]     r_s1_a;
    logic [W-2:0]     r_s1_b;
    logic [W-1:0]     r_s1_c;
    logic [TAG_W-1:0] r_s1_tag;
    logic             r_s1_vld;
    pl_t              r_s2;
    pl_t              w_pl [0:NN];
    logic             w_stall;
    logic             w_busy;
    logic             w_unused;

    assign w_stall  = out_valid && !out_ready;
    assign in_ready = !w_stall && !flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_a   <= '0;
            r_s1_b   <= '0;
            r_s1_c   <= '0;
            r_s1_tag <= '0;
            r_s1_vld <= 1'b0;
        end else if (flush) begin
            r_s1_vld <= 1'b0;
        end else if (!w_stall) begin
            r_s1_a   <= in_1;
            r_s1_b   <= in_2;
            r_s1_c   <= in_3;
            r_s1_tag <= in_tag;
            r_s1_vld <= in_valid;
        end
    end

    // Operands are (W-1)-bit, so the W-bit sum cannot overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s2 <= '0;
        end else if (flush) begin
            r_s2.vld <= 1'b0;
        end else if (!w_stall) begin
            r_s2.acc <= '0;
            r_s2.res <= '0;
            r_s2.a   <= {1'b0, r_s1_a} + {1'b0, r_s1_b};
            r_s2.b   <= r_s1_c;
            r_s2.tag <= r_s1_tag;
            r_s2.vld <= r_s1_vld;
        end
    end

    assign w_pl[0] = r_s2;

    for (genvar s = 0; s < NN; s++) begin : g_pp
        pipe_addmul_stage #(
            .W    (W),
            .LIMB (LIMB),
            .I    (pp_i(W, LIMB, s)),
            .J    (pp_j(W, LIMB, s)),
            .pl_t (pl_t)
        ) u_pp (
            .clk     (clk),
            .rst_n   (rst_n),
            .i_hold  (w_stall),
            .i_flush (flush),
            .i_pl    (w_pl[s]),
            .o_pl    (w_pl[s+1])
        );
    end

    assign out_valid = w_pl[NN].vld;
    assign out       = w_pl[NN].res;
    assign out_tag   = w_pl[NN].tag;

    always_comb begin
        w_busy = r_s1_vld | r_s2.vld;
        for (int s = 1; s <= NN; s++)
            w_busy = w_busy | w_pl[s].vld;
    end

    assign busy     = w_busy;
    assign w_unused = ^{w_pl[NN].acc, w_pl[NN].a, w_pl[NN].b};

endmodule

// File: tb/tb_pipe_addmul_bp.sv
// Scoreboard bench for pipe_addmul_bp: default 32/16 instance plus a 48/16 instance.
module tb_pipe_addmul_bp;

    localparam int LAT   = 6;
    localparam int LAT48 = 11;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        flush = 1'b0;
    logic        out_ready = 1'b1;
    logic [30:0] in_1 = '0;
    logic [30:0] in_2 = '0;
    logic [31:0] in_3 = '0;
    logic [3:0]  in_tag = '0;
    logic        in_ready, out_valid, busy;
    logic [63:0] out;
    logic [3:0]  out_tag;

    logic        v48 = 1'b0, fl48 = 1'b0, or48 = 1'b1;
    logic [46:0] a48 = '0, b48 = '0;
    logic [47:0] c48 = '0;
    logic [3:0]  t48 = '0;
    logic        r48, ov48, busy48;
    logic [95:0] o48;
    logic [3:0]  ot48;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic [63:0] p;
        logic [3:0]  t;
    } exp_t;
    exp_t q[$];

    always #5 clk = ~clk;

    pipe_addmul_bp dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_1(in_1), .in_2(in_2), .in_3(in_3), .in_tag(in_tag), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .out(out), .out_tag(out_tag),
        .busy(busy)
    );

    pipe_addmul_bp #(.W(48), .LIMB(16), .TAG_W(4)) dut48 (
        .clk(clk), .rst_n(rst_n), .in_valid(v48), .in_ready(r48),
        .in_1(a48), .in_2(b48), .in_3(c48), .in_tag(t48), .flush(fl48),
        .out_valid(ov48), .out_ready(or48), .out(o48), .out_tag(ot48),
        .busy(busy48)
    );

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] model(input logic [30:0] a, input logic [30:0] b,
                                          input logic [31:0] c);
        logic [63:0] s;
        s = 64'(a) + 64'(b);
        return s * 64'(c);
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            q.delete();
        end else begin
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    chk("unexpected_out", 128'(out_valid), 128'(0));
                end else begin
                    e = q.pop_front();
                    chk("out", 128'(out), 128'(e.p));
                    chk("out_tag", 128'(out_tag), 128'(e.t));
                end
            end
            if (flush) begin
                chk("flush_in_ready", 128'(in_ready), 128'(0));
                q.delete();
            end else if (in_valid && in_ready) begin
                e.p = model(in_1, in_2, in_3);
                e.t = in_tag;
                q.push_back(e);
            end
        end
    end

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic send(input logic [30:0] a, input logic [30:0] b,
                        input logic [31:0] c, input logic [3:0] t);
        int k;
        in_1 = a; in_2 = b; in_3 = c; in_tag = t; in_valid = 1'b1;
        for (k = 0; k < 200; k++) begin
            @(negedge clk);
            if (in_ready) break;
            @(posedge clk); #1;
        end
        if (k == 200) chk("send_timeout", 128'(in_ready), 128'(1));
        @(posedge clk); #1;
    endtask

    task automatic lat_op(input logic [30:0] a, input logic [30:0] b,
                          input logic [31:0] c, input logic [3:0] t);
        int first, cnt;
        send(a, b, c, t);
        in_valid = 1'b0;
        first = -1;
        cnt = 0;
        for (int cy = 1; cy <= LAT + 6; cy++) begin
            @(negedge clk);
            if (out_valid) begin
                cnt++;
                if (first < 0) first = cy;
            end
        end
        chk("latency", 128'(first), 128'(LAT));
        chk("valid_pulses", 128'(cnt), 128'(1));
        @(posedge clk); #1;
    endtask

    task automatic drain();
        int k;
        for (k = 0; k < 200; k++) begin
            @(negedge clk);
            if (q.size() == 0 && !busy) break;
        end
        chk("drain_busy", 128'(busy), 128'(0));
        chk("drain_pending", 128'(q.size()), 128'(0));
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int first, cnt;
        logic [95:0] g48;
        logic [3:0]  gt48;

        repeat (2) @(negedge clk);
        chk("rst_out_valid", 128'(out_valid), 128'(0));
        chk("rst_busy", 128'(busy), 128'(0));
        chk("rst_out", 128'(out), 128'(0));
        chk("rst_out_tag", 128'(out_tag), 128'(0));
        chk("rst_in_ready", 128'(in_ready), 128'(1));
        chk("rst_out_valid48", 128'(ov48), 128'(0));
        @(posedge clk); #1 rst_n = 1'b1;

        lat_op(31'd3, 31'd4, 32'd5, 4'h2);
        lat_op(31'h7FFF_FFFF, 31'h7FFF_FFFF, 32'hFFFF_FFFF, 4'h9);
        lat_op(31'h0123_4567, 31'h0765_4321, 32'd0, 4'h3);

        // Stream 8 ops while the consumer refuses the first result for 5 cycles.
        out_ready = 1'b0;
        fork
            begin
                for (int t = 0; t < 8; t++)
                    send(31'(t * 1000 + 7), 31'h7FFF_0000 - 31'(t), 32'hDEAD_0000 + 32'(t), 4'(t));
                in_valid = 1'b0;
            end
            begin
                int k;
                for (k = 0; k < 100; k++) begin
                    @(negedge clk);
                    if (out_valid) break;
                end
                chk("stall_first_valid", 128'(out_valid), 128'(1));
                for (int s = 0; s < 5; s++) begin
                    chk("stall_in_ready", 128'(in_ready), 128'(0));
                    chk("stall_valid", 128'(out_valid), 128'(1));
                    chk("stall_hold", 128'(out), 128'(model(31'd7, 31'h7FFF_0000, 32'hDEAD_0000)));
                    chk("stall_tag", 128'(out_tag), 128'(0));
                    if (s < 4) @(negedge clk);
                end
                @(posedge clk); #1 out_ready = 1'b1;
            end
        join
        drain();

        fork
            begin
                for (int t = 0; t < 24; t++)
                    send(31'($urandom), 31'($urandom), $urandom, 4'($urandom));
                in_valid = 1'b0;
            end
            begin
                for (int k = 0; k < 80; k++) begin
                    @(posedge clk); #1 out_ready = ($urandom_range(0, 3) != 0);
                end
                out_ready = 1'b1;
            end
        join
        drain();

        // Flush with three ops in flight and a fresh op offered in the same cycle.
        send(31'd11, 31'd12, 32'd13, 4'hA);
        send(31'd21, 31'd22, 32'd23, 4'hB);
        send(31'd31, 31'd32, 32'd33, 4'hC);
        in_1 = 31'd41; in_2 = 31'd42; in_3 = 32'd43; in_tag = 4'hF;
        flush = 1'b1;
        @(posedge clk); #1 flush = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        chk("flush_busy", 128'(busy), 128'(0));
        chk("flush_out_valid", 128'(out_valid), 128'(0));
        cnt = 0;
        for (int cy = 0; cy < 12; cy++) begin
            @(negedge clk);
            if (out_valid) cnt++;
        end
        chk("flush_ghost", 128'(cnt), 128'(0));
        @(posedge clk); #1;
        lat_op(31'h0000_BEEF, 31'h0000_0001, 32'h0001_0003, 4'h5);

        // Asynchronous reset while four ops are in flight.
        for (int t = 0; t < 4; t++)
            send(31'(t + 100), 31'(t + 200), 32'(t + 300), 4'(t + 8));
        in_valid = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        chk("armid_out", 128'(out), 128'(0));
        chk("armid_out_valid", 128'(out_valid), 128'(0));
        chk("armid_busy", 128'(busy), 128'(0));
        chk("armid_out_tag", 128'(out_tag), 128'(0));
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_in_ready", 128'(in_ready), 128'(1));
        @(posedge clk); #1;
        lat_op(31'd1000, 31'd2000, 32'd3000, 4'h6);
        drain();

        // 48-bit instance, max operands.
        a48 = 47'h7FFF_FFFF_FFFF; b48 = 47'h7FFF_FFFF_FFFF;
        c48 = 48'hFFFF_FFFF_FFFF; t48 = 4'hC; v48 = 1'b1;
        @(negedge clk);
        chk("w48_in_ready", 128'(r48), 128'(1));
        @(posedge clk); #1 v48 = 1'b0;
        first = -1;
        g48 = '0;
        gt48 = '0;
        for (int cy = 1; cy <= LAT48 + 4; cy++) begin
            @(negedge clk);
            if (ov48 && first < 0) begin
                first = cy;
                g48 = o48;
                gt48 = ot48;
            end
        end
        chk("w48_latency", 128'(first), 128'(LAT48));
        chk("w48_out", 128'(g48), 128'(96'hFFFF_FFFF_FFFD_0000_0000_0002));
        chk("w48_tag", 128'(gt48), 128'(4'hC));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/pipe_addmul_bp.md
Name: pipe_addmul_bp

Overview:
- Parametrised, backpressure-aware pipeline computing out = (in_1 + in_2) * in_3 exactly, using LIMB-wide partial products with one partial product per pipeline stage.
- Sits between an upstream producer and a downstream consumer using valid/ready handshakes.
- Carries a user tag alongside each operation and supports a synchronous flush.
- Successor to the fixed 32-bit, no-stall add-multiply pipe.

Parameters:
- W, 32, width of in_3 and of the zero-extended sum; must be a multiple of LIMB and at least 2*LIMB.
- LIMB, 16, partial-product limb width; N = W/LIMB limbs per operand.
- TAG_W, 4, width of the tag carried with each operation (at least 1).

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; asynchronous, active-low
- in_valid  in  1  input operation valid
- in_ready  out  1  pipeline can accept an operation this cycle
- in_1  in  W-1  addend A, unsigned
- in_2  in  W-1  addend B, unsigned
- in_3  in  W  multiplier, unsigned
- in_tag  in  TAG_W  user tag
- flush  in  1  synchronous discard of all in-flight operations
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts the result
- out  out  2W  product (in_1+in_2)*in_3
- out_tag  out  TAG_W  tag of the result
- busy  out  1  at least one stage holds a valid operation

Behaviour:
- Reset state: all stage valid bits, out_valid, out, out_tag and busy are 0. in_ready is 1 whenever out_valid is 0.
- Reset is asynchronous and may assert mid-operation; all in-flight operations are discarded with no partial output.
- Arithmetic:
  - sum = in_1 + in_2, computed as a W-bit value; it never overflows (max 2^W-2).
  - out is the full 2W-bit unsigned product. All values are unsigned; no truncation or saturation.
- Structure:
  - S1 registers the inputs.
  - S2 registers the sum and splits sum and in_3 into N limbs each.
  - S3 through S(2+N*N) each add exactly one LIMB×LIMB partial product, in schoolbook order: low limb pair first, ascending result weight.
  - A stage commits a result limb once no later partial product can affect it, and carries the upper bits forward.
  - The final stage drives out and out_tag.
- Latency: L = 2 + N*N cycles from acceptance to out_valid, with no stalls (6 for the defaults).
- Throughput: one operation per cycle when out_ready is held high.
- Handshake:
  - Accept occurs when in_valid && in_ready.
  - Stall condition: stall = out_valid && !out_ready. in_ready = !stall.
  - During a stall every stage register (data, tag, valid) holds. Bubbles are not collapsed.
  - The result is consumed when out_valid && out_ready.
  - out and out_tag stay stable while out_valid=1 and out_ready=0.
  - in_valid may drop without a transfer; no ordering constraint on in_valid vs in_ready.
- Flush:
  - Next cycle, all stage valid bits and out_valid are 0 and busy is 0.
  - Operands presented in the flush cycle are not accepted: in_ready is forced to 0 while flush=1.
  - Flush takes priority over stall and over accept.
- busy = OR of all stage valid bits including out_valid.
- Back-to-back operations with distinct tags must emerge in order, each with its own tag.
- Corner values: in_3 = 0 gives out = 0. Max operands must produce the exact product (see Test Plan).

Decomposition:
- Package pipe_addmul_pkg:
  - function n_limbs(W, LIMB) and function pipe_latency(W, LIMB) = 2 + n*n.
  - Stage payload struct: partial sum, committed result limbs, operand limbs, tag, valid.
- Sub-module pipe_addmul_stage: one partial-product stage.
  - Parameters: limb index pair (i, j).
  - Inputs: stage payload and hold enable.
  - Output: registered payload.
  - Instantiated N*N times with a generate loop. Top level holds S1, S2, stall/flush control and busy.

Test Plan:
- Basic: in_1=3, in_2=4, in_3=5, tag=0x2, out_ready=1 → exactly 6 cycles later out=0x23, out_tag=0x2, out_valid pulses 1 cycle.
- Max operands: in_1=in_2=0x7FFFFFFF, in_3=0xFFFFFFFF → out=0xFFFFFFFD_00000002.
- Streaming with backpressure: 8 back-to-back ops (tags 0..7). Hold out_ready=0 for 5 cycles while the first result is valid → in_ready=0 during the stall, out holds its value, all 8 results arrive in order with correct tags, none lost or duplicated.
- Flush: 3 ops in flight, assert flush 1 cycle → next cycle busy=0, out_valid=0, no results ever emerge. A new op issued afterwards returns correctly after 6 cycles.
- Reset mid-operation: rst_n low while 4 ops in flight → out=0, out_valid=0, busy=0 immediately. After release, in_ready=1 and a new op completes normally.
- W=48, LIMB=16: in_1=in_2=0x7FFFFFFFFFFF, in_3=0xFFFFFFFFFFFF → latency 11, out = (2^48-2)*(2^48-1) exact (0xFFFFFFFFFFFD_000000000002).
